// File: rtl/parallel_to_serial_stream_pkg.sv
// parallel_to_serial_stream_pkg: state encodings shared by serial stream producers and consumers
package parallel_to_serial_stream_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/parallel_to_serial_stream.sv
// parallel_to_serial_stream: loads COUNT signed elements in parallel and emits one per beat with index/last/done
module parallel_to_serial_stream
  import parallel_to_serial_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT       = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [COUNT*WIDTH-1:0]        in,
  input  logic                          hold,
  output logic                          enable,
  output logic signed [WIDTH-1:0]       out,
  output logic [INDEX_WIDTH-1:0]        index,
  output logic                          last,
  output logic                          busy,
  output logic                          done
);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(COUNT - 1);
  state_t r_state, w_next;
  logic [COUNT*WIDTH-1:0] r_buf;
  logic [INDEX_WIDTH-1:0] r_cnt;
  logic w_beat, w_last_beat;
  always_comb begin
    w_beat      = (r_state == STREAM) && !hold;
    w_last_beat = w_beat && (r_cnt == LAST_IDX);
    w_next      = (r_state == IDLE)   ? (load ? STREAM : IDLE) :
                  (r_state == STREAM) ? (w_last_beat ? DONE : STREAM) :
                  (done ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // DONE spans the pulse cycle plus the cycle that retires busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
      out    <= '0;
      index  <= '0;
      last   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      r_buf  <= '0;
      r_cnt  <= '0;
    end else begin
      enable <= w_beat;
      last   <= w_last_beat;
      done   <= (r_state == DONE) && !done;
      busy   <= (r_state == IDLE) ? load : !((r_state == DONE) && done);
      if ((r_state == IDLE) && load) begin
        r_buf <= in;
        r_cnt <= '0;
      end
      if (w_beat) begin
        out   <= r_buf[r_cnt*WIDTH +: WIDTH];
        index <= r_cnt;
        if (!w_last_beat) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// tb_parallel_to_serial_stream: directed stimulus, per-cycle compare against a beat-schedule model
module tb_parallel_to_serial_stream;
  logic clk = 0, rst = 1;
  logic load8 = 0, hold8 = 0, load1 = 0, hold1 = 0;
  logic [63:0] in8 = '0;
  logic [7:0] in1 = '0;
  logic en8, last8, busy8, done8, en1, last1, busy1, done1;
  logic signed [7:0] out8, out1;
  logic [2:0] idx8;
  logic [0:0] idx1;
  int total = 0, bad = 0;

  parallel_to_serial_stream #(.WIDTH(8), .COUNT(8), .INDEX_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .in(in8), .hold(hold8), .enable(en8),
    .out(out8), .index(idx8), .last(last8), .busy(busy8), .done(done8));
  parallel_to_serial_stream #(.WIDTH(8), .COUNT(1), .INDEX_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .in(in1), .hold(hold1), .enable(en1),
    .out(out1), .index(idx1), .last(last1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 streaming beat k, 2 last beat sent, 3 done pulse shown
  int ph = 0, k = 0, vec[8];
  int m_en = 0, m_out = 0, m_idx = 0, m_last = 0, m_busy = 0, m_done = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; k = 0;
      m_en = 0; m_out = 0; m_idx = 0; m_last = 0; m_busy = 0; m_done = 0;
    end else if (ph == 0) begin
      m_en = 0; m_last = 0; m_done = 0; m_busy = 0;
      if (load8) begin
        for (int j = 0; j < 8; j++) vec[j] = $signed(in8[j*8 +: 8]);
        k = 0; ph = 1; m_busy = 1;
      end
    end else if (ph == 1) begin
      if (hold8) begin
        m_en = 0; m_last = 0;
      end else begin
        m_en = 1; m_out = vec[k]; m_idx = k; m_last = (k == 7);
        if (k == 7) ph = 2; else k++;
      end
    end else if (ph == 2) begin
      m_en = 0; m_last = 0; m_done = 1; ph = 3;
    end else begin
      m_done = 0; m_busy = 0; ph = 0;
    end
  end

  // Consumer-side argmax: first maximum wins
  int best = 0, bidx = 0, seen = 0, am = -1;
  always @(negedge clk) begin
    chk("enable", en8, m_en);
    chk("out", out8, m_out);
    chk("index", idx8, m_idx);
    chk("last", last8, m_last);
    chk("busy", busy8, m_busy);
    chk("done", done8, m_done);
    if (en8 && !rst) begin
      if (!seen || out8 > best) begin best = out8; bidx = idx8; end
      seen = 1;
      if (last8) begin am = bidx; seen = 0; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [63:0] v);
    in8 = v; load8 = 1;
    step(1);
    load8 = 0;
  endtask

  initial begin
    step(2);
    chk("rst_enable", en8, 0);
    chk("rst_busy", busy8, 0);
    rst = 0;
    go8({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
    step(1);
    chk("beat0_en", en8, 1);
    chk("beat0_idx", idx8, 0);
    step(7);
    chk("beat7_out", out8, 7);
    chk("beat7_last", last8, 1);
    step(1);
    chk("done_pulse", done8, 1);
    step(1);
    chk("done_clear", done8, 0);
    chk("busy_clear", busy8, 0);
    go8({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
    step(3);
    hold8 = 1;
    step(3);
    chk("hold_en", en8, 0);
    chk("hold_out", out8, 2);
    chk("hold_idx", idx8, 2);
    hold8 = 0;
    step(1);
    chk("resume_out", out8, 3);
    step(10);
    go8({8'hFF, 8'd127, 8'd3, 8'd0, 8'd127, 8'h80, 8'd12, 8'hFB});
    step(3);
    in8 = {8{8'd99}}; load8 = 1;
    step(1);
    load8 = 0;
    step(8);
    chk("argmax", am, 3);
    step(2);
    go8({8{8'd99}});
    step(1);
    chk("reload_out", out8, 99);
    step(12);
    go8({8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10});
    step(5);
    chk("pre_rst_out", out8, 14);
    #2 rst = 1;
    #1;
    chk("arst_en", en8, 0);
    chk("arst_out", out8, 0);
    chk("arst_busy", busy8, 0);
    step(1);
    rst = 0;
    go8({8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20});
    step(1);
    chk("post_rst_out", out8, 20);
    chk("post_rst_idx", idx8, 0);
    step(12);
    in1 = 8'hFD; load1 = 1;
    step(1);
    load1 = 0;
    step(1);
    chk("c1_en", en1, 1);
    chk("c1_out", out1, -3);
    chk("c1_idx", idx1, 0);
    chk("c1_last", last1, 1);
    step(1);
    chk("c1_en_off", en1, 0);
    chk("c1_done", done1, 1);
    step(1);
    chk("c1_busy", busy1, 0);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
